// File: rtl/multiplicador_secuencial_4_bit_pkg.sv
`timescale 1ns/1ps
// Shared constants for the shift-and-add multiplier: FSM encodings and default width.
package multiplicador_secuencial_4_bit_pkg;

    localparam int N_DEF = 4;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_CALC = 2'd1,
        ST_DONE = 2'd2
    } state_t;

endpackage

// File: rtl/multiplicador_secuencial_4_bit_if.sv
`timescale 1ns/1ps
// Operand/product handshake bundle; master is the producer/consumer side, slave the multiplier.
interface multiplicador_secuencial_4_bit_if
    import multiplicador_secuencial_4_bit_pkg::*;
#(
    parameter int N = N_DEF
);
    logic           in_valid;
    logic           in_ready;
    logic [N-1:0]   a;
    logic [N-1:0]   b;
    logic           out_valid;
    logic           out_ready;
    logic [2*N-1:0] producto;

    modport master (
        output in_valid, a, b, out_ready,
        input  in_ready, out_valid, producto
    );

    modport slave (
        input  in_valid, a, b, out_ready,
        output in_ready, out_valid, producto
    );
endinterface

// File: rtl/multiplicador_secuencial_4_bit_etapa_suma_nb.sv
`timescale 1ns/1ps
// Combinational N-bit ripple-carry adder built from 1-bit full-adder cells.
module fa_1b (
    input  logic x,
    input  logic y,
    input  logic c_in,
    output logic s,
    output logic c_out
);
    assign s     = x ^ y ^ c_in;
    assign c_out = (x & y) | (c_in & (x ^ y));
endmodule

module etapa_suma_nb #(
    parameter int N = 4
) (
    input  logic [N-1:0] x,
    input  logic [N-1:0] y,
    input  logic         c_in,
    output logic [N-1:0] s,
    output logic         c_out
);
    logic [N:0] cy;

    assign cy[0] = c_in;

    for (genvar i = 0; i < N; i++) begin : g_bit
        fa_1b u_fa (
            .x     (x[i]),
            .y     (y[i]),
            .c_in  (cy[i]),
            .s     (s[i]),
            .c_out (cy[i+1])
        );
    end

    assign c_out = cy[N];
endmodule

// File: rtl/multiplicador_secuencial_4_bit.sv
`timescale 1ns/1ps
// Unsigned shift-and-add multiplier: one add+shift per cycle, product N cycles after accept.
// Holds the product in DONE until out_ready; new operands only accepted in IDLE.
module multiplicador_secuencial_4_bit
    import multiplicador_secuencial_4_bit_pkg::*;
#(
    parameter int N = N_DEF
) (
    input  logic clk,
    input  logic rst,
    multiplicador_secuencial_4_bit_if.slave bus
);
    localparam int CW = $clog2(N) + 1;

    state_t         state;
    state_t         state_nx;
    logic [N-1:0]   m;
    logic [N-1:0]   q;
    logic [N-1:0]   acc;
    logic [CW-1:0]  cnt;

    logic [N-1:0]   sum_y;
    logic [N-1:0]   sum_s;
    logic           sum_c;
    logic           last_step;

    logic           idle_ready;
    logic           done_valid;
    logic [2*N-1:0] prod_out;

    assign sum_y     = q[0] ? m : '0;
    assign last_step = (cnt == CW'(N - 1));

    etapa_suma_nb #(.N(N)) u_suma (
        .x     (acc),
        .y     (sum_y),
        .c_in  (1'b0),
        .s     (sum_s),
        .c_out (sum_c)
    );

    always_ff @(posedge clk) begin
        if (rst) state <= ST_IDLE;
        else     state <= state_nx;
    end

    always_comb begin
        state_nx   = state;
        idle_ready = 1'b0;
        done_valid = 1'b0;
        prod_out   = '0;
        case (state)
            ST_IDLE: begin
                idle_ready = 1'b1;
                if (bus.in_valid) state_nx = ST_CALC;
            end
            ST_CALC: begin
                if (last_step) state_nx = ST_DONE;
            end
            ST_DONE: begin
                done_valid = 1'b1;
                prod_out   = {acc, q};
                if (bus.out_ready) state_nx = ST_IDLE;
            end
            default: state_nx = ST_IDLE;
        endcase
    end

    // The step's carry lands in acc's MSB, so {acc,q} never overflows 2N bits.
    always_ff @(posedge clk) begin
        if (rst) begin
            m   <= '0;
            q   <= '0;
            acc <= '0;
            cnt <= '0;
        end else begin
            case (state)
                ST_IDLE: begin
                    if (bus.in_valid) begin
                        m   <= bus.a;
                        q   <= bus.b;
                        acc <= '0;
                        cnt <= '0;
                    end
                end
                ST_CALC: begin
                    acc <= {sum_c, sum_s[N-1:1]};
                    q   <= {sum_s[0], q[N-1:1]};
                    cnt <= cnt + CW'(1);
                end
                default: ;
            endcase
        end
    end

    assign bus.in_ready  = idle_ready;
    assign bus.out_valid = done_valid;
    assign bus.producto  = prod_out;
endmodule

// File: tb/tb_multiplicador_secuencial_4_bit.sv
`timescale 1ns/1ps
// Directed bench for the sequential multiplier, plus an exhaustive 4x4 sweep.
module tb_multiplicador_secuencial_4_bit;

    logic clk;
    logic rst;
    int   n_chk;
    int   n_fail;
    int   cyc;

    multiplicador_secuencial_4_bit_if #(.N(4)) bus ();

    multiplicador_secuencial_4_bit #(.N(4)) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_chk++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0d expected %0d", tag, got, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
        cyc++;
    endtask

    // Accept operands and wait for out_valid; returns edges from accept to out_valid.
    task automatic accept_wait(input logic [3:0] x, input logic [3:0] y, input string tag,
                               output int lat);
        chk({tag, "_ready_before"}, 32'(bus.in_ready), 32'd1);
        bus.a = x;
        bus.b = y;
        bus.in_valid = 1'b1;
        tick();
        bus.in_valid = 1'b0;
        chk({tag, "_ready_drop"}, 32'(bus.in_ready), 32'd0);
        lat = 0;
        while (!bus.out_valid && lat < 20) begin
            tick();
            lat++;
        end
        chk({tag, "_valid_seen"}, 32'(bus.out_valid), 32'd1);
    endtask

    task automatic release_out(input string tag);
        bus.out_ready = 1'b1;
        tick();
        bus.out_ready = 1'b0;
        chk({tag, "_valid_drop"}, 32'(bus.out_valid), 32'd0);
        chk({tag, "_ready_back"}, 32'(bus.in_ready), 32'd1);
    endtask

    task automatic do_mult(input logic [3:0] x, input logic [3:0] y, input logic [7:0] exp,
                           input string tag);
        int lat;
        accept_wait(x, y, tag, lat);
        chk({tag, "_latency"}, 32'(lat), 32'd4);
        chk({tag, "_prod"}, 32'(bus.producto), 32'(exp));
        release_out(tag);
    endtask

    initial begin
        int lat;
        int seen;
        int t_prev;
        logic [3:0] op_a [3];
        logic [3:0] op_b [3];
        logic [7:0] op_p [3];

        n_chk = 0;
        n_fail = 0;
        cyc = 0;
        rst = 1'b1;
        bus.in_valid = 1'b0;
        bus.out_ready = 1'b0;
        bus.a = '0;
        bus.b = '0;
        tick();
        tick();
        rst = 1'b0;

        chk("rst_in_ready", 32'(bus.in_ready), 32'd1);
        chk("rst_out_valid", 32'(bus.out_valid), 32'd0);
        chk("rst_producto", 32'(bus.producto), 32'd0);

        do_mult(4'd3, 4'd5, 8'h0F, "m3x5");
        do_mult(4'd15, 4'd15, 8'hE1, "m15x15");
        do_mult(4'd0, 4'd9, 8'h00, "m0x9");
        do_mult(4'd9, 4'd0, 8'h00, "m9x0");

        // Consumer stall with an ignored operand pulse.
        accept_wait(4'd7, 4'd6, "stall", lat);
        chk("stall_latency", 32'(lat), 32'd4);
        for (int i = 0; i < 3; i++) begin
            bus.in_valid = (i == 0);
            bus.a = 4'd1;
            bus.b = 4'd1;
            tick();
            bus.in_valid = 1'b0;
            chk("stall_valid_hold", 32'(bus.out_valid), 32'd1);
            chk("stall_prod_hold", 32'(bus.producto), 32'd42);
            chk("stall_no_ready", 32'(bus.in_ready), 32'd0);
        end
        release_out("stall");
        do_mult(4'd1, 4'd1, 8'd1, "m1x1");

        // Reset sampled on the second CALC edge.
        bus.a = 4'd9;
        bus.b = 4'd9;
        bus.in_valid = 1'b1;
        tick();
        bus.in_valid = 1'b0;
        tick();
        rst = 1'b1;
        tick();
        rst = 1'b0;
        chk("abort_in_ready", 32'(bus.in_ready), 32'd1);
        chk("abort_out_valid", 32'(bus.out_valid), 32'd0);
        chk("abort_producto", 32'(bus.producto), 32'd0);
        seen = 0;
        for (int i = 0; i < 8; i++) begin
            tick();
            if (bus.out_valid || !bus.in_ready) seen++;
        end
        chk("abort_no_stale", 32'(seen), 32'd0);

        // Back-to-back with in_valid and out_ready held high.
        op_a = '{4'd2, 4'd10, 4'd15};
        op_b = '{4'd3, 4'd11, 4'd1};
        op_p = '{8'd6, 8'd110, 8'd15};
        bus.out_ready = 1'b1;
        bus.in_valid = 1'b1;
        t_prev = 0;
        for (int i = 0; i < 3; i++) begin
            bus.a = op_a[i];
            bus.b = op_b[i];
            chk("b2b_ready", 32'(bus.in_ready), 32'd1);
            tick();
            bus.a = 4'd0;
            bus.b = 4'd0;
            lat = 0;
            while (!bus.out_valid && lat < 20) begin
                tick();
                lat++;
            end
            chk("b2b_latency", 32'(lat), 32'd4);
            chk("b2b_prod", 32'(bus.producto), 32'(op_p[i]));
            if (i > 0) chk("b2b_period", 32'(cyc - t_prev), 32'd6);
            t_prev = cyc;
            if (i == 2) bus.in_valid = 1'b0;
            tick();
        end
        bus.out_ready = 1'b0;
        chk("b2b_idle", 32'(bus.in_ready), 32'd1);

        // Every operand pair against the bench's own product.
        for (int x = 0; x < 16; x++) begin
            for (int y = 0; y < 16; y++) begin
                do_mult(4'(x), 4'(y), 8'(x * y), "sweep");
            end
        end

        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end

    initial begin
        #2_000_000;
        $display("FAIL timeout: simulation did not finish, got 0 expected 1");
        $fatal(1, "timeout");
    end

endmodule
